elastic_rr_arbiter: RTL and testbench
=====================================

# elastic_rr_arbiter

Round-robin arbiter that shares one elastic output stage among `ports_p` vector requesters. Each requester presents a `depth_p`-lane vector of `width_p`-bit elements with valid/ready handshake. The selected beat is registered into a single output stage with the same handshake semantics as the codebase's elastic buffer. It sits in front of shared datapath resources such as the systolic-array input feeder and the accumulator writeback path, where several producers compete for one consumer.

## Interface
- `width_p`, 8, element width in bits
- `depth_p`, 8, lanes per vector beat
- `ports_p`, 4, number of requesters; legal range 2..16
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_i`  in  1  asynchronous active-high reset
- `data_i`  in  `ports_p` x `depth_p` x `width_p`  per-requester vector payload (unpacked arrays)
- `valid_i`  in  `ports_p`  per-requester valid
- `last_i`  in  `ports_p`  per-requester end-of-burst flag
- `ready_o`  out  `ports_p`  per-requester ready; one-hot or zero
- `valid_o`  out  1  output beat valid
- `data_o`  out  `depth_p` x `width_p`  output vector
- `last_o`  out  1  last flag of the output beat
- `id_o`  out  `max(1, $clog2(ports_p))`  index of the requester that supplied the output beat
- `ready_i`  in  1  downstream ready

## Operation
- **Stage enable:** `accept = ~valid_o | ready_i`. This is the same rule as the elastic stage, so full throughput is preserved under continuous `ready_i`.
- **Round-robin pointer:** `ptr` ranges over 0..ports_p-1.
  - Candidates are searched in order `ptr`, `ptr+1`, … with wrap modulo `ports_p`.
  - The first candidate with `valid_i` set is the winner.
- **Ready outputs:**
  - `ready_o[winner] = accept`.
  - All other `ready_o` bits are 0.
  - With no valid requester, all `ready_o` bits are 0.
- **Transfer:** occurs when `valid_i[winner] & ready_o[winner]`. On a transfer:
  - `data_o <= data_i[winner]`, `last_o <= last_i[winner]`, `id_o <= winner`, `valid_o <= 1`.
  - `ptr <= (winner+1) mod ports_p`. This assumes no lock is active; see Configuration.
- **No transfer while `accept`:** `valid_o <= 0`. `data_o`, `last_o` and `id_o` hold.
- **No `accept`:** all output registers hold, i.e. the stage is stalled.
- **Fairness:** a continuously valid requester is granted within `ports_p` transfers.
- **Upstream rule:** `valid_i` must not depend combinationally on `ready_o`. Once asserted, `valid_i` and its data are held until the transfer.
- **Reset values:** `valid_o`=0, `data_o`=all zeros, `last_o`=0, `id_o`=0, `ptr`=0, lock state cleared.
  - Reset asserted mid-burst or mid-stall drops the held beat; no beat is replayed.
  - Reset asserts asynchronously and deasserts synchronously to `clk_i` (via an external synchronizer).

## Timing
- Latency is 1 cycle: a transfer at edge N makes the beat visible on `valid_o`/`data_o` after edge N.
- Throughput is 1 beat per cycle with `ready_i`=1.
- Combinational paths:
  - `ready_i` → `ready_o`
  - `valid_i` → `ready_o` (through arbitration)
  - No path from `valid_i` or `data_i` to any output other than `ready_o`.
- **Simultaneous output drain and refill:** with `valid_o`=1 and `ready_i`=1, the current beat leaves and the next beat loads on the same edge.
- **Pointer wrap:** a winner of `ports_p-1` sets `ptr` to 0.
- **Backpressure:** while `valid_o`=1 and `ready_i`=0:
  - all `ready_o` bits are 0;
  - `ptr` and lock state hold;
  - outputs are stable.

## Configuration
- **`ELASTIC_RR_ARBITER_LOCK_EN` defined:** burst lock is active.
  - A transfer with `last_i`=0 sets `locked`=1 and `lock_id`=winner.
  - While locked, only `lock_id` is a candidate, and `ptr` does not advance.
  - A transfer from `lock_id` with `last_i`=1 clears `locked` and sets `ptr` to `(lock_id+1) mod ports_p`.
  - An idle locked requester (`valid_i`=0) blocks all other requesters.
- **Macro undefined:**
  - `last_i` is passed through to `last_o` only.
  - Arbitration happens on every beat.
  - No lock state exists.

## Test plan
- **Reset:** assert `rst_i` mid-cycle with `valid_o`=1 → `valid_o`, `last_o`, `id_o` and `data_o` read 0 immediately and all `ready_o` bits are 0.
- **Round-robin sweep:** all 4 requesters valid continuously, `ready_i`=1 → `id_o` sequence is 0,1,2,3,0,1; one beat per cycle; `data_o` equals the granted `data_i`.
- **Backpressure:** requesters 1 and 3 valid, `ready_i`=0 for 3 cycles after the first beat (id 1) → `data_o` and `id_o` hold at 1 and `ready_o`=0000; after `ready_i`=1, the next id is 3.
- **Sparse and wrap:** only requester 3 valid, then only requester 0 → `id_o` 3 then 0, with `ptr` wrapping to 0 and then 1.
- **Lock (macro defined):** requester 2 sends 3 beats with `last_i` pattern 0,0,1 while requester 0 is valid → `id_o` is 2,2,2 and then 0.
  - Without the macro, the same stimulus interleaves ids as 2,0,…
- **Fairness soak:** 1000 cycles of random `valid_i` and `ready_i` with held-valid sources → no beat lost or duplicated, and no requester waits more than 4 transfers.

Source files
------------

// File: rtl/elastic_rr_arbiter_if.sv
// Handshake bundle between the vector requesters, the round-robin arbiter and its downstream consumer.
interface elastic_rr_arbiter_if #(
    parameter int unsigned width_p = 8,
    parameter int unsigned depth_p = 8,
    parameter int unsigned ports_p = 4
);
    localparam int unsigned id_w = (ports_p > 1) ? $clog2(ports_p) : 1;

    logic [width_p-1:0] data_i [ports_p][depth_p];
    logic [ports_p-1:0] valid_i;
    logic [ports_p-1:0] last_i;
    logic [ports_p-1:0] ready_o;
    logic               valid_o;
    logic [width_p-1:0] data_o [depth_p];
    logic               last_o;
    logic [id_w-1:0]    id_o;
    logic               ready_i;

    // Requester/consumer side (drives payloads and downstream ready)
    modport master (
        output data_i, valid_i, last_i, ready_i,
        input  ready_o, valid_o, data_o, last_o, id_o
    );

    // Arbiter side
    modport slave (
        input  data_i, valid_i, last_i, ready_i,
        output ready_o, valid_o, data_o, last_o, id_o
    );
endinterface

// File: rtl/elastic_rr_arbiter.sv
// Round-robin arbiter feeding one registered elastic output stage shared by several vector requesters.
// Define ELASTIC_RR_ARBITER_LOCK_EN to hold the grant on one requester until its last_i beat.
module elastic_rr_arbiter #(
    parameter int unsigned width_p = 8,
    parameter int unsigned depth_p = 8,
    parameter int unsigned ports_p = 4
) (
    input logic                clk_i,
    input logic                rst_i,
    elastic_rr_arbiter_if.slave bus
);
    localparam int unsigned id_w = (ports_p > 1) ? $clog2(ports_p) : 1;

    logic [id_w-1:0]    ptr_q;
    logic [id_w-1:0]    winner;
    logic [id_w-1:0]    cand;
    logic [id_w-1:0]    next_ptr;
    logic [ports_p-1:0] cand_mask;
    logic [ports_p-1:0] ready_c;
    logic               found;
    logic               accept;
    logic               xfer;

    logic               valid_q;
    logic               last_q;
    logic [id_w-1:0]    id_q;
    logic [width_p-1:0] data_q [depth_p];

`ifdef ELASTIC_RR_ARBITER_LOCK_EN
    logic               locked_q;
    logic [id_w-1:0]    lock_id_q;

    // While a burst is open only its owner may compete
    always_comb begin
        cand_mask = bus.valid_i;
        if (locked_q) begin
            cand_mask = bus.valid_i & (ports_p'(1) << lock_id_q);
        end
    end
`else
    assign cand_mask = bus.valid_i;
`endif

    assign accept = ~valid_q | bus.ready_i;

    // First valid candidate at or after ptr, wrapping modulo ports_p
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 0; k < ports_p; k++) begin
            cand = id_w'((32'(ptr_q) + k) % ports_p);
            if (!found && cand_mask[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign next_ptr = (32'(winner) == ports_p - 1) ? '0 : winner + id_w'(1);
    assign xfer     = found & accept & ~rst_i;

    always_comb begin
        ready_c = '0;
        if (xfer) begin
            ready_c[winner] = 1'b1;
        end
    end

    // Output stage: load on transfer, empty on idle accept, hold on stall
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            id_q    <= '0;
            data_q  <= '{default: '0};
        end else if (accept) begin
            valid_q <= xfer;
            if (xfer) begin
                data_q <= bus.data_i[winner];
                last_q <= bus.last_i[winner];
                id_q   <= winner;
            end
        end
    end

`ifdef ELASTIC_RR_ARBITER_LOCK_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q     <= '0;
            locked_q  <= 1'b0;
            lock_id_q <= '0;
        end else if (xfer) begin
            // Pointer parks while a burst is open and moves past its owner on the closing beat
            if (!locked_q || bus.last_i[winner]) begin
                ptr_q <= next_ptr;
            end
            locked_q  <= ~bus.last_i[winner];
            lock_id_q <= winner;
        end
    end
`else
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (xfer) begin
            ptr_q <= next_ptr;
        end
    end
`endif

    assign bus.ready_o = ready_c;
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.last_o  = last_q;
    assign bus.id_o    = id_q;
endmodule

// File: tb/tb_elastic_rr_arbiter.sv
// Directed and random bench for elastic_rr_arbiter using a behavioural arbiter model and a beat scoreboard.
module tb_elastic_rr_arbiter;
    localparam int unsigned W  = 8;
    localparam int unsigned D  = 8;
    localparam int unsigned P  = 4;
    localparam int unsigned IW = 2;
`ifdef ELASTIC_RR_ARBITER_LOCK_EN
    localparam int FAIR_BOUND = 3 * (P - 1);
`else
    localparam int FAIR_BOUND = P;
`endif

    typedef struct packed {
        logic [IW-1:0]  id;
        logic           last;
        logic [D*W-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    elastic_rr_arbiter_if #(.width_p(W), .depth_p(D), .ports_p(P)) bus ();
    elastic_rr_arbiter #(.width_p(W), .depth_p(D), .ports_p(P)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int    checks = 0;
    int    failures = 0;
    beat_t sb[$];
    int    seen_ids[$];
    beat_t m_hold;
    bit    m_valid, m_locked, fair_on;
    int    m_ptr, m_lock_id, sent, recv;
    int    src_left[P], src_cnt[P], wait_cnt[P];
    bit    src_pkt[P];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] lane(input int p, input int c, input int l);
        return W'(p * 61 + c * 13 + l * 7 + 3);
    endfunction

    function automatic bit src_last(input int p);
        return src_pkt[p] ? 1'b1 : (src_left[p] == 1);
    endfunction

    task automatic drive_srcs();
        for (int p = 0; p < P; p++) begin
            bus.valid_i[p] = (src_left[p] > 0);
            bus.last_i[p]  = src_last(p);
            for (int l = 0; l < D; l++) bus.data_i[p][l] = lane(p, src_cnt[p], l);
        end
    endtask

    task automatic clear_model();
        m_valid = 0; m_locked = 0; m_ptr = 0; m_lock_id = 0;
        m_hold = '0;
        sb.delete();
        seen_ids.delete();
        for (int p = 0; p < P; p++) begin
            src_left[p] = 0; wait_cnt[p] = 0; src_pkt[p] = 1'b1;
        end
    endtask

    // One clock: check ready_o against the model, push expected beat, then check the registered output
    task automatic tick();
        bit found, acc, xfer;
        int win, c;
        logic [P-1:0]   exp_rdy;
        logic [D*W-1:0] got;
        beat_t b;
        drive_srcs();
        #1;
        acc = !m_valid || (bus.ready_i === 1'b1);
        found = 0; win = 0;
        for (int k = 0; k < P; k++) begin
            c = (m_ptr + k) % P;
            if (!found && src_left[c] > 0 && (!m_locked || c == m_lock_id)) begin
                found = 1; win = c;
            end
        end
        xfer = found && acc;
        exp_rdy = '0;
        if (xfer) exp_rdy[win] = 1'b1;
        chk("ready_o", 64'(bus.ready_o), 64'(exp_rdy));
        b = '0;
        if (xfer) begin
            b.id = IW'(win);
            b.last = src_last(win);
            for (int l = 0; l < D; l++) b.data[l*W +: W] = lane(win, src_cnt[win], l);
            sb.push_back(b);
            if (fair_on) chk("fair_wait", 64'(wait_cnt[win] <= FAIR_BOUND), 64'(1));
            for (int p = 0; p < P; p++) if (p != win && src_left[p] > 0) wait_cnt[p]++;
            wait_cnt[win] = 0;
            sent++;
        end
        @(posedge clk);
        #1;
        if (acc) m_valid = xfer;
        if (xfer) begin
`ifdef ELASTIC_RR_ARBITER_LOCK_EN
            if (m_locked) begin
                if (b.last) begin
                    m_locked = 0;
                    m_ptr = (m_lock_id + 1) % P;
                end
            end else begin
                m_ptr = (win + 1) % P;
                if (!b.last) begin
                    m_locked = 1;
                    m_lock_id = win;
                end
            end
`else
            m_ptr = (win + 1) % P;
`endif
            src_cnt[win]++;
            src_left[win]--;
        end
        chk("valid_o", 64'(bus.valid_o), 64'(m_valid));
        for (int l = 0; l < D; l++) got[l*W +: W] = bus.data_o[l];
        if (xfer) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                b = sb.pop_front();
                chk("beat_id", 64'(bus.id_o), 64'(b.id));
                chk("beat_last", 64'(bus.last_o), 64'(b.last));
                chk("beat_data", 64'(got), 64'(b.data));
                m_hold = b;
                recv++;
                seen_ids.push_back(int'(bus.id_o));
            end
        end else if (m_valid) begin
            chk("hold_id", 64'(bus.id_o), 64'(m_hold.id));
            chk("hold_last", 64'(bus.last_o), 64'(m_hold.last));
            chk("hold_data", 64'(got), 64'(m_hold.data));
        end
    endtask

    // Asynchronous reset between edges; outputs and ready_o must clear at once
    task automatic do_reset();
        logic [D*W-1:0] got;
        #2 rst = 1'b1;
        #1;
        for (int l = 0; l < D; l++) got[l*W +: W] = bus.data_o[l];
        chk("rst_valid_o", 64'(bus.valid_o), 64'(0));
        chk("rst_data_o", 64'(got), 64'(0));
        chk("rst_last_o", 64'(bus.last_o), 64'(0));
        chk("rst_id_o", 64'(bus.id_o), 64'(0));
        chk("rst_ready_o", 64'(bus.ready_o), 64'(0));
        clear_model();
        drive_srcs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_ids(input string tag, input int exp[$]);
        chk({tag, "_count"}, 64'(seen_ids.size() >= exp.size()), 64'(1));
        for (int i = 0; i < exp.size() && i < seen_ids.size(); i++)
            chk(tag, 64'(seen_ids[i]), 64'(exp[i]));
    endtask

    initial begin
        int exp_ids[$];
        rst = 1'b1;
        fair_on = 0; sent = 0; recv = 0;
        for (int p = 0; p < P; p++) src_cnt[p] = 0;
        clear_model();
        bus.ready_i = 1'b0;
        drive_srcs();
        #12;
        chk("init_valid_o", 64'(bus.valid_o), 64'(0));
        chk("init_ready_o", 64'(bus.ready_o), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Round-robin sweep with all requesters valid
        bus.ready_i = 1'b1;
        for (int p = 0; p < P; p++) src_left[p] = 10;
        for (int n = 0; n < 6; n++) tick();
        exp_ids = '{0, 1, 2, 3, 0, 1};
        chk_ids("rr_id", exp_ids);
        chk("rr_valid_before_rst", 64'(bus.valid_o), 64'(1));
        do_reset();

        // Backpressure with requesters 1 and 3
        bus.ready_i = 1'b1;
        src_left[1] = 1; src_left[3] = 1;
        tick();
        bus.ready_i = 1'b0;
        for (int n = 0; n < 3; n++) tick();
        bus.ready_i = 1'b1;
        tick();
        tick();
        exp_ids = '{1, 3};
        chk_ids("bp_id", exp_ids);

        // Sparse requests and pointer wrap
        src_left[3] = 1;
        tick();
        src_left[0] = 1;
        tick();
        tick();
        seen_ids = seen_ids[2:$];
        exp_ids = '{3, 0};
        chk_ids("wrap_id", exp_ids);
        do_reset();

        // Burst from requester 2 (last 0,0,1) competing with requester 0
        bus.ready_i = 1'b1;
        src_left[2] = 3; src_pkt[2] = 1'b0;
        tick();
        src_left[0] = 2;
        for (int n = 0; n < 5; n++) tick();
`ifdef ELASTIC_RR_ARBITER_LOCK_EN
        exp_ids = '{2, 2, 2, 0};
`else
        exp_ids = '{2, 0, 2, 0};
`endif
        chk_ids("lock_id", exp_ids);
        do_reset();

        // Random soak with held-valid bursty sources
        fair_on = 1;
        sent = 0; recv = 0;
        for (int p = 0; p < P; p++) src_pkt[p] = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            for (int p = 0; p < P; p++)
                if (src_left[p] == 0 && $urandom_range(2, 0) == 0) src_left[p] = int'($urandom_range(3, 1));
            bus.ready_i = ($urandom_range(3, 0) != 0);
            tick();
        end
        bus.ready_i = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (src_left[0] == 0 && src_left[1] == 0 && src_left[2] == 0 && src_left[3] == 0 && !m_valid) break;
            tick();
        end
        chk("soak_drained", 64'(m_valid), 64'(0));
        chk("soak_sb_empty", 64'(sb.size()), 64'(0));
        chk("soak_sent_recv", 64'(recv), 64'(sent));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
